prio_arbiter_rr: RTL

Parametrised request arbiter, the registered successor of the 4-to-2 priority encoder. It accepts N request lines and selects one of them. There are two modes: fixed priority (highest index wins) and round-robin. The selected grant is presented as an index plus a one-hot vector under a valid/ready handshake, and it sits in front of shared resources such as bus ports and FIFO write sides.

---
 rtl/prio_arbiter_rr_pkg.sv | 12 +
 rtl/prio_pick_desc.sv | 29 ++
 rtl/prio_arbiter_rr.sv | 88 ++++++++
 3 files changed

// File: rtl/prio_arbiter_rr_pkg.sv
// Shared constants and state encoding for the registered request arbiter.
package prio_arbiter_rr_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/prio_pick_desc.sv
// Combinational descending priority pick: scans start, start-1, ... with wrap
// and returns the first set bit. With N=4, start=3 it is the legacy 4-to-2 encoder.
module prio_pick_desc
  import prio_arbiter_rr_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    int pos;
    pos   = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(start) - k + N) % N;
      if (!found && vec[pos]) begin
        found = 1'b1;
        idx   = W'(pos);
      end
    end
  end

endmodule

// File: rtl/prio_arbiter_rr.sv
// Registered N-way request arbiter with fixed-priority and round-robin modes,
// presenting its grant as index plus one-hot under a valid/ready handshake.
module prio_arbiter_rr
  import prio_arbiter_rr_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot
);

  arb_state_t   r_state;
  arb_state_t   w_state_nxt;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;
  logic [W-1:0] r_ptr;

  logic         w_enable;
  logic         w_accept;
  logic [W-1:0] w_ptr_eff;
  logic [W-1:0] w_start;
  logic         w_found;
  logic [W-1:0] w_pick_idx;

  assign w_accept = (r_state == ST_HOLD) && gnt_ready;
  assign w_enable = (r_state == ST_IDLE) || gnt_ready;

  // An accepting cycle arbitrates with the already-advanced pointer so the
  // channel just served drops to lowest priority immediately.
  assign w_ptr_eff = !w_accept        ? r_ptr :
                     (r_idx == '0)    ? W'(N - 1) :
                                        r_idx - 1'b1;

  assign w_start = (mode == MODE_RR) ? w_ptr_eff : W'(N - 1);

  prio_pick_desc #(
    .N (N),
    .W (W)
  ) u_pick (
    .vec   (req),
    .start (w_start),
    .found (w_found),
    .idx   (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_onehot <= '0;
      r_ptr    <= W'(N - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_ptr <= w_ptr_eff;
      end
      if (w_enable) begin
        if (w_found) begin
          r_idx    <= w_pick_idx;
          r_onehot <= {{(N-1){1'b0}}, 1'b1} << w_pick_idx;
        end else begin
          r_onehot <= '0;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_enable) begin
      w_state_nxt = w_found ? ST_HOLD : ST_IDLE;
    end
  end

  always_comb begin
    gnt_valid  = (r_state == ST_HOLD);
    gnt_idx    = r_idx;
    gnt_onehot = r_onehot;
  end

endmodule
